div128: RTL
===========

# div128

Iterative unsigned divider: divides a 2·DATA_WIDTH-bit dividend by a DATA_WIDTH-bit divisor and returns a DATA_WIDTH-bit quotient and remainder. It is the inverse datapath of the 128×128 multiplier: a full product fed back in with one of its factors returns the other factor and a zero remainder. It uses restoring radix-2 division at one quotient bit per cycle. Valid/ready handshakes on both sides let it sit between the modular-arithmetic control and the multiplier results.

## Interface
- DATA_WIDTH, 128: divisor/quotient/remainder width; dividend is 2·DATA_WIDTH.
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  dividend/divisor valid
- in_ready  out  1  block can accept an operation
- dividend  in  2·DATA_WIDTH  numerator, sampled on input handshake
- divisor  in  DATA_WIDTH  denominator, sampled on input handshake
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  DATA_WIDTH  result quotient
- remainder  out  DATA_WIDTH  result remainder
- err  out  1  divide-by-zero or quotient overflow

## Operation
- FSM states IDLE, CALC, DONE.
- IDLE: in_ready=1. Input handshake (in_valid && in_ready) latches the operands.
  - If divisor==0 or dividend[2W-1:W] >= divisor: go to DONE with err=1, quotient='1, remainder='0.
  - Otherwise: go to CALC with rem=dividend[2W-1:W], q=dividend[W-1:0], divisor register loaded, counter=0.
- CALC, one step per cycle:
  - t = {rem, q[W-1]} (W+1 bits).
  - If t >= divisor: rem = t − divisor, new bit = 1. Else: rem = t[W-1:0], new bit = 0.
  - q = {q[W-2:0], new bit}; counter increments.
  - After step with counter==W-1: go to DONE, err=0.
- The precondition (high half < divisor) guarantees rem < divisor at every step and that the quotient fits in W bits.
- DONE: out_valid=1. quotient, remainder and err are held stable until out_ready=1, then go to IDLE.
- in_valid is ignored outside IDLE. The block has no operand queue.
- Reset (any state, including mid-CALC): state=IDLE, in_ready=1, out_valid=0, quotient/remainder/err=0, counter=0. The partial result is discarded.

## Timing
- Accept edge = cycle 0.
- Normal path: W cycles in CALC, out_valid high from cycle W+1 (129 for default).
- Error path: out_valid high from cycle 1.
- in_ready is registered and combinationally equal to (state==IDLE). It is low from the cycle after accept until the cycle after the output handshake.
- No same-cycle turnaround: the output handshake and a new input acceptance cannot share a cycle. Minimum throughput is one op per W+2 cycles.
- Outputs are registered with no combinational path from any input to any output.
- out_valid never drops without out_ready=1 on the preceding edge.

## Structure
- Shared package div_pkg:
  - state typedef div_state_e {IDLE, CALC, DONE}.
  - counter width constant $clog2(DATA_WIDTH).
- One sub-module, div128_step: combinational single iteration.
  - Inputs: rem, next dividend bit, divisor.
  - Outputs: new rem, quotient bit.
  - Instanced once, so a future unrolled multi-step version only needs additional instances.
- The top level holds the FSM, counter, and operand/result registers.

## Test plan
- Basic divide: dividend=100, divisor=7 -> quotient=14, remainder=2, err=0. out_valid rises exactly 129 cycles after accept.
- Full-product inverse: dividend=(2^128−1)^2, divisor=2^128−1 -> quotient=2^128−1, remainder=0, err=0.
- Divide by zero: dividend=12345, divisor=0 -> err=1, quotient=all ones, remainder=0, out_valid one cycle after accept.
- Quotient overflow: dividend=5·2^128, divisor=5 -> err=1 on the one-cycle path. Then dividend=5·2^128−1, divisor=5 -> quotient=2^128−1, remainder=4, err=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, toggling in_valid with new operands -> quotient/remainder/err stable, in_ready=0, extra inputs not accepted. Release out_ready -> in_ready=1 next cycle.
- Reset mid-operation: assert rst_n=0 at CALC step 50 -> out_valid=0 and all outputs 0 immediately. After release, in_ready=1, and dividend=100, divisor=7 again yields 14 r 2.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } div_state_e;

   localparam int DIV_W     = 128;
   localparam int DIV_CNT_W = $clog2(DIV_W);

endpackage

// File: rtl/div128_step.sv
// One restoring radix-2 iteration: shift in a dividend bit, conditionally subtract.
module div128_step #(
   parameter int DATA_WIDTH = 128
) (
   input  logic [DATA_WIDTH-1:0] rem_i,
   input  logic                  bit_i,
   input  logic [DATA_WIDTH-1:0] divisor,
   output logic [DATA_WIDTH-1:0] rem_o,
   output logic                  q_bit
);

   logic [DATA_WIDTH:0] t;

   assign t     = {rem_i, bit_i};
   assign q_bit = (t >= {1'b0, divisor});
   // rem_i < divisor keeps the difference below 2^W, so the low W bits are exact
   assign rem_o = q_bit ? (t[DATA_WIDTH-1:0] - divisor) : t[DATA_WIDTH-1:0];

endmodule

// File: rtl/div128.sv
// Iterative unsigned 2W/W divider, one quotient bit per cycle, valid/ready on both sides.
module div128
   import div_pkg::*;
#(
   parameter int DATA_WIDTH = DIV_W
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [2*DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0]   divisor,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   quotient,
   output logic [DATA_WIDTH-1:0]   remainder,
   output logic                    err
);

   localparam int CNT_W = $clog2(DATA_WIDTH);

   div_state_e            state;
   logic [CNT_W-1:0]      cnt;
   logic [DATA_WIDTH-1:0] rem_q;
   logic [DATA_WIDTH-1:0] q_q;
   logic [DATA_WIDTH-1:0] dvsr_q;
   logic [DATA_WIDTH-1:0] rem_nxt;
   logic                  q_bit;
   logic [DATA_WIDTH-1:0] dvd_hi;

   assign dvd_hi = dividend[2*DATA_WIDTH-1:DATA_WIDTH];

   div128_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
      .rem_i   (rem_q),
      .bit_i   (q_q[DATA_WIDTH-1]),
      .divisor (dvsr_q),
      .rem_o   (rem_nxt),
      .q_bit   (q_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         err       <= 1'b0;
         cnt       <= '0;
         rem_q     <= '0;
         q_q       <= '0;
         dvsr_q    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  dvsr_q   <= divisor;
                  cnt      <= '0;
                  // high half >= divisor covers both /0 and a quotient wider than W
                  if (divisor == '0 || dvd_hi >= divisor) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     err       <= 1'b1;
                     quotient  <= '1;
                     remainder <= '0;
                  end else begin
                     state <= CALC;
                     rem_q <= dvd_hi;
                     q_q   <= dividend[DATA_WIDTH-1:0];
                  end
               end
            end
            CALC: begin
               rem_q <= rem_nxt;
               q_q   <= {q_q[DATA_WIDTH-2:0], q_bit};
               cnt   <= cnt + 1'b1;
               if (cnt == CNT_W'(DATA_WIDTH-1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  err       <= 1'b0;
                  quotient  <= {q_q[DATA_WIDTH-2:0], q_bit};
                  remainder <= rem_nxt;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
